seg_display_rx: RTL
===================

// Module: seg_display_rx
//
// PURPOSE
//  Receiver for the multiplexed 4-digit 7-segment display bus. It watches the
//  anode and segment lines, decodes each settled digit back to its hex nibble
//  and dot, and publishes a complete 16-bit frame. Used for on-board loopback
//  self-test of display drivers and as a bus monitor in system benches.
//
// PARAMETERS
//  SETTLE_CYCLES  4  consecutive identical input cycles before a digit is captured (>=1)
//
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset, asynchronous, active-low
//  i_anodes    in   4   digit select, active-low, bit n = position n
//  i_segments  in   8   [7:1]=ABCDEFG active-high, [0]=dot
//  i_err_clr   in   1   clears o_err (synchronous, 1-cycle pulse)
//  o_data      out  16  last complete frame, [3:0]=pos0 .. [15:12]=pos3
//  o_dots      out  4   last complete frame dots, bit n = pos n
//  o_valid     out  1   1-cycle pulse: o_data/o_dots updated this cycle
//  o_err       out  2   sticky: [0] illegal anode pattern, [1] undecodable segments
//
// BEHAVIOUR
//  - Reset: o_data=0, o_dots=0, o_valid=0, o_err=0; input regs, stability counter,
//    shadow regs, captured mask and capture-done flag all cleared.
//  - Inputs registered once ({anodes,segments} -> r_bus); all logic uses r_bus.
//  - Stability counter: cleared when r_bus != previous r_bus, else +1, saturating
//    at SETTLE_CYCLES; width $clog2(SETTLE_CYCLES+1).
//  - Capture event: counter reaches SETTLE_CYCLES-1 on an unchanged bus (i.e. bus
//    identical for SETTLE_CYCLES cycles) and capture-done flag clear; flag set on
//    capture, cleared on any bus change -> exactly one capture per dwell.
//  - Anode classification at capture: exactly one bit low -> pos = that index;
//    4'b1111 -> blank, no capture, no error; anything else -> o_err[0]<=1, no capture.
//  - Segment decode ABCDEFG -> nibble: 7E=0 30=1 6D=2 79=3 33=4 5B=5 5F=6 70=7
//    7F=8 7B=9 77=A 1F=B 4E=C 3D=D 4F=E 47=F. Other code -> nibble 0, o_err[1]<=1,
//    capture still completes (mask bit set).
//  - Capture writes shadow nibble[pos], shadow dot[pos]=segments[0], mask[pos]<=1.
//    Re-capture of an already-set pos overwrites shadow, mask unchanged.
//  - Frame complete: when (mask | capture bit) == 4'b1111, next cycle o_data/o_dots
//    <= shadow (including the digit just captured), o_valid=1 for one cycle, mask
//    cleared. Order of positions irrelevant.
//  - Latency: input change -> capture = 1 (input reg) + SETTLE_CYCLES cycles;
//    4th capture -> o_valid one cycle later.
//  - o_err bits sticky; i_err_clr clears both; same-cycle new error wins (bit stays 1).
//  - o_data/o_dots hold between frames; asynchronous reset mid-frame discards
//    partial frame, a full 4-digit frame is required before next o_valid.
//
// TESTING
//  1 SETTLE=4; pos0..3 = 7E,30,6D,79 (dot 0) each held 6 cycles -> single o_valid, o_data=16'h3210, o_dots=0.
//  2 pos1 pattern held 3 cycles then changed, rest of frame normal -> no capture of it, o_valid only after pos1 held >=4 cycles.
//  3 anodes=4'b1100 held 8 cycles -> o_err=2'b01, mask unchanged, no o_valid; pulse i_err_clr -> o_err=0.
//  4 pos2 segments 7'b0000001 held, others valid -> o_err[1]=1, frame completes, o_data[11:8]=0.
//  5 capture pos0,pos1 then assert rst_n=0 mid-dwell -> all outputs 0; next frame needs all 4 digits before o_valid.
//  6 frame F,E,D,C with dot on pos1,pos3; repeat same frame continuously -> o_valid every frame, o_data=16'hCDEF, o_dots=4'b1010.

Source files
------------

// File: rtl/seg_display_rx.sv
// Receiver for the multiplexed 4-digit 7-segment bus: waits for each digit to settle,
// decodes it back to a nibble and dot, and publishes a complete 16-bit frame.
module seg_display_rx #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  i_anodes,
   input  logic [7:0]  i_segments,
   input  logic        i_err_clr,
   output logic [15:0] o_data,
   output logic [3:0]  o_dots,
   output logic        o_valid,
   output logic [1:0]  o_err
);

   localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

   logic [11:0]   bus_q, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [3:0]    sdot_q, sdot_d;
   logic [3:0]    mask_q, mask_d;
   logic          pend_q, pend_d;
   logic [15:0]   data_q;
   logic [3:0]    dots_q;
   logic          valid_q;
   logic [1:0]    err_q, err_d;

   logic          changed, dwell, legal, blank, known, cap;
   logic [CW:0]   run_len;
   logic [1:0]    pos;
   logic [3:0]    nib, posbit;
   logic [6:0]    seg7;

   always_comb begin
      changed = (bus_q != prev_q);
      // run_len counts the cycle in which the new value first appeared
      run_len = changed ? (CW+1)'(1) : ({1'b0, cnt_q} + (CW+1)'(2));
      dwell   = (run_len >= (CW+1)'(SETTLE_CYCLES)) && (changed || !done_q);

      legal = 1'b1;
      blank = 1'b0;
      pos   = '0;
      case (bus_q[11:8])
         4'b1110: pos = 2'd0;
         4'b1101: pos = 2'd1;
         4'b1011: pos = 2'd2;
         4'b0111: pos = 2'd3;
         4'b1111: begin legal = 1'b0; blank = 1'b1; end
         default: legal = 1'b0;
      endcase

      seg7  = bus_q[7:1];
      known = 1'b1;
      case (seg7)
         7'h7E: nib = 4'h0;
         7'h30: nib = 4'h1;
         7'h6D: nib = 4'h2;
         7'h79: nib = 4'h3;
         7'h33: nib = 4'h4;
         7'h5B: nib = 4'h5;
         7'h5F: nib = 4'h6;
         7'h70: nib = 4'h7;
         7'h7F: nib = 4'h8;
         7'h7B: nib = 4'h9;
         7'h77: nib = 4'hA;
         7'h1F: nib = 4'hB;
         7'h4E: nib = 4'hC;
         7'h3D: nib = 4'hD;
         7'h4F: nib = 4'hE;
         7'h47: nib = 4'hF;
         default: begin nib = 4'h0; known = 1'b0; end
      endcase

      cap    = dwell && legal;
      posbit = 4'b0001 << pos;

      cnt_d    = changed ? '0 : ((cnt_q == CW'(SETTLE_CYCLES)) ? cnt_q : cnt_q + 1'b1);
      done_d   = changed ? dwell : (done_q | dwell);
      shadow_d = shadow_q;
      sdot_d   = sdot_q;
      mask_d   = mask_q;
      pend_d   = 1'b0;
      err_d    = i_err_clr ? '0 : err_q;

      if (cap) begin
         shadow_d[{pos, 2'b00} +: 4] = nib;
         sdot_d[pos]                 = bus_q[0];
         if ((mask_q | posbit) == 4'b1111) begin
            mask_d = '0;
            pend_d = 1'b1;
         end else begin
            mask_d = mask_q | posbit;
         end
      end
      if (dwell && !legal && !blank) err_d[0] = 1'b1;
      if (cap && !known)             err_d[1] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_q    <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         shadow_q <= '0;
         sdot_q   <= '0;
         mask_q   <= '0;
         pend_q   <= 1'b0;
         data_q   <= '0;
         dots_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= '0;
      end else begin
         bus_q    <= {i_anodes, i_segments};
         prev_q   <= bus_q;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         shadow_q <= shadow_d;
         sdot_q   <= sdot_d;
         mask_q   <= mask_d;
         pend_q   <= pend_d;
         valid_q  <= pend_q;
         err_q    <= err_d;
         if (pend_q) begin
            data_q <= shadow_q;
            dots_q <= sdot_q;
         end
      end
   end

   assign o_data  = data_q;
   assign o_dots  = dots_q;
   assign o_valid = valid_q;
   assign o_err   = err_q;

endmodule
